// File: rtl/muldiv_unit_pkg.sv
// Shared op definitions for the EX-stage multiply/divide unit.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package muldiv_unit_pkg;

  // The core maps ALU_OP_MULT/MULTU/DIV/DIVU onto this encoding.
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  function automatic logic md_is_div(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX stage (master) and the muldiv unit (slave).
// Latency: n/a (wires only).
// Backpressure: master must not rely on start being taken while busy is high.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  import muldiv_unit_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial remainder.
// Latency: combinational.
// Backpressure: none.
module muldiv_unit_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,      // partial remainder already shifted left with next dividend bit
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] diff;
  logic           fits;

  // Keep the difference when it does not go negative, else restore the old remainder.
  always_comb begin
    diff   = rem_i - {1'b0, divisor_i};
    fits   = ~diff[WIDTH];
    qbit_o = fits;
    rem_o  = fits ? diff[WIDTH-1:0] : rem_i[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide for the EX stage, results presented as HI/LO with a done pulse.
// Latency: MUL_STAGES cycles for multiply, WIDTH/DIV_BITS_PER_CYCLE+1 cycles for divide.
// Backpressure: busy high while an op is in flight; starts are ignored then, flush aborts.
module muldiv_unit #(
  parameter int WIDTH              = 32,
  parameter int MUL_STAGES         = 2,  // >= 1
  parameter int DIV_BITS_PER_CYCLE = 1   // must divide WIDTH
) (
  input logic          clk,
  input logic          resetn,
  muldiv_unit_if.slave bus
);
  import muldiv_unit_pkg::*;

  localparam int N       = WIDTH / DIV_BITS_PER_CYCLE;
  // Counter also paces the multiplier, so size it for whichever wait is longer.
  localparam int CNT_MAX = (N > MUL_STAGES) ? N : MUL_STAGES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PW      = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept;
  assign accept = bus.start & ~busy_q & ~bus.flush;

  // ---------------------------------------------------------------- operands
  logic             in_sgn;
  logic             a_neg_in;
  logic             b_neg_in;
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag_in;

  // Magnitudes of the incoming operands; signed ops fold the sign out here.
  always_comb begin
    in_sgn   = md_is_signed(bus.op);
    a_neg_in = in_sgn & bus.a[WIDTH-1];
    b_neg_in = in_sgn & bus.b[WIDTH-1];
    a_mag_in = a_neg_in ? -bus.a : bus.a;
    b_mag_in = b_neg_in ? -bus.b : bus.b;
  end

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mul_sgn_q;
  logic [WIDTH-1:0] dvs_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;

  // --------------------------------------------------------------- multiplier
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_sgn;
  logic [PW-1:0]    mul_x;
  logic [PW-1:0]    mul_y;
  logic [PW-1:0]    mul_prod;
  logic [PW-1:0]    mul_res;

  // Single-stage multiply has no spare cycle, so it works straight off the request.
  // Sign-extending to 2*WIDTH makes one unsigned multiply serve both signednesses.
  always_comb begin
    if (MUL_STAGES == 1) begin
      mul_a   = bus.a;
      mul_b   = bus.b;
      mul_sgn = in_sgn;
    end else begin
      mul_a   = a_q;
      mul_b   = b_q;
      mul_sgn = mul_sgn_q;
    end
    mul_x    = {{WIDTH{mul_sgn & mul_a[WIDTH-1]}}, mul_a};
    mul_y    = {{WIDTH{mul_sgn & mul_b[WIDTH-1]}}, mul_b};
    mul_prod = mul_x * mul_y;
  end

  if (MUL_STAGES > 2) begin : g_mul_pipe
    logic [PW-1:0] pipe_q [MUL_STAGES-2];

    // Free-running stages behind the multiplier for retiming; operands stay put for the op.
    always_ff @(posedge clk) begin
      pipe_q[0] <= mul_prod;
      for (int i = 1; i < MUL_STAGES - 2; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign mul_res = pipe_q[MUL_STAGES-3];
  end else begin : g_mul_direct
    assign mul_res = mul_prod;
  end

  // ------------------------------------------------------------------ divider
  // The first chain pass runs in the accept cycle on the fresh magnitudes, the
  // remaining N-1 passes run from the latched remainder/quotient.
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] step_dvs;
  logic [WIDTH-1:0] chain_rem;
  logic [WIDTH-1:0] chain_quo;

  // Select chain source: fresh operands when idle, iteration state otherwise.
  always_comb begin
    if (state_q == ST_IDLE) begin
      step_rem = '0;
      step_quo = a_mag_in;
      step_dvs = b_mag_in;
    end else begin
      step_rem = rem_q;
      step_quo = quo_q;
      step_dvs = dvs_q;
    end
  end

  // quo_in shifts dividend bits out at the top while quotient bits enter at the bottom.
  for (genvar k = 0; k < DIV_BITS_PER_CYCLE; k++) begin : g_div_chain
    logic [WIDTH-1:0] rem_in;
    logic [WIDTH-1:0] quo_in;
    logic [WIDTH-1:0] rem_out;
    logic [WIDTH-1:0] quo_out;
    logic             qbit;

    if (k == 0) begin : g_first
      assign rem_in = step_rem;
      assign quo_in = step_quo;
    end else begin : g_next
      assign rem_in = g_div_chain[k-1].rem_out;
      assign quo_in = g_div_chain[k-1].quo_out;
    end

    muldiv_unit_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     ({rem_in, quo_in[WIDTH-1]}),
      .divisor_i (step_dvs),
      .rem_o     (rem_out),
      .qbit_o    (qbit)
    );

    assign quo_out = {quo_in[WIDTH-2:0], qbit};
  end

  assign chain_rem = g_div_chain[DIV_BITS_PER_CYCLE-1].rem_out;
  assign chain_quo = g_div_chain[DIV_BITS_PER_CYCLE-1].quo_out;

  // Latch operands on accept and advance the divider once per cycle while dividing.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q       <= bus.a;
      b_q       <= bus.b;
      mul_sgn_q <= in_sgn;
      dvs_q     <= b_mag_in;
      q_neg_q   <= a_neg_in ^ b_neg_in;
      r_neg_q   <= a_neg_in;
      rem_q     <= chain_rem;
      quo_q     <= chain_quo;
    end else if (state_q == ST_DIV) begin
      rem_q     <= chain_rem;
      quo_q     <= chain_quo;
    end
  end

  // Sign correction of the magnitude result. INT_MIN / -1 falls out as INT_MIN
  // remainder 0 without special casing; divide by zero overrides everything.
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  // Final quotient/remainder as presented on LO/HI.
  always_comb begin
    fix_lo = q_neg_q ? -quo_q : quo_q;
    fix_hi = r_neg_q ? -rem_q : rem_q;
    if (dvs_q == '0) begin
      fix_lo = '1;
      fix_hi = a_q;
    end
  end

  // -------------------------------------------------------------------- FSM
  // Control FSM with registered busy/done and HI/LO result registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.start) begin
              if (md_is_div(bus.op)) begin
                state_q <= (N == 1) ? ST_FIX : ST_DIV;
                busy_q  <= 1'b1;
                cnt_q   <= CNT_W'(1);
              end else if (MUL_STAGES == 1) begin
                done_q       <= 1'b1;
                {hi_q, lo_q} <= mul_res;
              end else begin
                state_q <= ST_MUL;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
              end
            end
          end
          ST_MUL: begin
            if (cnt_q == CNT_W'(MUL_STAGES - 2)) begin
              state_q      <= ST_IDLE;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              cnt_q        <= '0;
              {hi_q, lo_q} <= mul_res;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_DIV: begin
            if (cnt_q == CNT_W'(N - 1)) begin
              state_q <= ST_FIX;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_FIX: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= fix_hi;
            lo_q    <= fix_lo;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, multi-cycle corner sequences, random ops.
// Latency: n/a.
// Backpressure: start is pulsed randomly while busy to confirm it is ignored.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W  = 32;
  localparam int MS = 2;
  localparam int DB = 1;
  localparam int N  = W / DB;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  muldiv_unit_if #(.WIDTH(W)) bus();

  muldiv_unit #(
    .WIDTH              (W),
    .MUL_STAGES         (MS),
    .DIV_BITS_PER_CYCLE (DB)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input muldiv_op_t op);
    return ((op == MD_DIV) || (op == MD_DIVU)) ? N + 1 : MS;
  endfunction

  // Reference: plain 64-bit arithmetic and SV's own truncating division.
  function automatic void model(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint unsigned pu;
    longint          ps;
    int              sa;
    int              sb;
    sa = $signed(a);
    sb = $signed(b);
    hi = '0;
    lo = '0;
    case (op)
      MD_MULTU: begin
        pu = {32'h0, a} * {32'h0, b};
        hi = pu[63:32];
        lo = pu[31:0];
      end
      MD_MULT: begin
        ps = longint'(sa) * longint'(sb);
        hi = ps[63:32];
        lo = ps[31:0];
      end
      MD_DIVU: begin
        if (b == 0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: begin
        if (b == 0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'h0;
        end else begin
          lo = sa / sb;
          hi = sa % sb;
        end
      end
    endcase
  endfunction

  // Issue one op at C0 and follow it to done; operands are scrambled after C0
  // and start is pulsed at random while busy.
  task automatic run_op(input string name, input muldiv_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    int lat;
    bit busy_ok;
    lat        = lat_of(op);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.a      = a;
    bus.b      = b;
    tick();
    cyc     = 1;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc <= lat + 20) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      bus.start = 1'($urandom_range(0, 1));
      bus.op    = muldiv_op_t'($urandom_range(0, 3));
      bus.a     = $urandom;
      bus.b     = $urandom;
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    check({name, " latency"}, cyc, lat);
    check({name, " busy before done"}, 32'(busy_ok), 32'd1);
    check({name, " busy in done cycle"}, 32'(bus.busy), 32'd0);
    check({name, " hi"}, bus.hi, exp_hi);
    check({name, " lo"}, bus.lo, exp_lo);
  endtask

  // Watch for a stray done over a window while idle.
  task automatic expect_quiet(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    check({name, " no done/busy"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] eh;
    logic [31:0] el;
    logic [31:0] ra;
    logic [31:0] rb;
    muldiv_op_t  rop;

    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = MD_MULT;
    bus.a     = '0;
    bus.b     = '0;

    vecs[0]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{MD_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[4]  = '{MD_DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    vecs[5]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6]  = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7]  = '{MD_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[8]  = '{MD_DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
    vecs[9]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[10] = '{MD_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    vecs[11] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[12] = '{MD_DIVU,  32'h0000_0003, 32'h0000_0007, 32'h0000_0003, 32'h0000_0000};
    vecs[13] = '{MD_MULT,  32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    // Reset state
    repeat (3) tick();
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    resetn = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
      tick();
      check($sformatf("vec%0d done one cycle", i), 32'(bus.done), 32'd0);
    end

    // Flush mid-divide: no done, HI/LO keep the previous result
    run_op("pre flush", MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);
    bus.start = 1'b1; bus.op = MD_DIV; bus.a = 32'd100; bus.b = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    check("flush busy at C10", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush busy at C11", 32'(bus.busy), 32'd0);
    expect_quiet("after flush", 40);
    check("flush keeps hi", bus.hi, 32'd0);
    check("flush keeps lo", bus.lo, 32'd15);

    // Flush during a multiply suppresses its done
    bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'd9; bus.b = 32'd9;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("mul flush done", 32'(bus.done), 32'd0);
    expect_quiet("after mul flush", 10);
    check("mul flush keeps lo", bus.lo, 32'd15);

    // Flush and start together: flush wins
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = MD_DIVU; bus.a = 32'd50; bus.b = 32'd5;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush+start busy", 32'(bus.busy), 32'd0);
    expect_quiet("flush+start", 40);
    check("flush+start keeps lo", bus.lo, 32'd15);

    // Reset mid-divide clears HI/LO and produces no done
    bus.start = 1'b1; bus.op = MD_DIV; bus.a = 32'd100; bus.b = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset hi", bus.hi, 32'd0);
    check("midreset lo", bus.lo, 32'd0);
    expect_quiet("after midreset", 40);

    // Back-to-back: DIVU started in the MULTU done cycle
    bus.start = 1'b1; bus.op = MD_MULTU; bus.a = 32'd3; bus.b = 32'd5;
    tick();
    bus.start = 1'b0;
    check("b2b mul busy C1", 32'(bus.busy), 32'd1);
    tick();
    check("b2b mul done C2", 32'(bus.done), 32'd1);
    check("b2b mul lo", bus.lo, 32'd15);
    run_op("b2b divu", MD_DIVU, 32'd10, 32'd3, 32'd1, 32'd3);
    tick();

    // Random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      rop = muldiv_op_t'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      model(rop, ra, rb, eh, el);
      run_op($sformatf("rnd%0d op%0d a=%h b=%h", i, rop, ra, rb), rop, ra, rb, eh, el);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
